// File: rtl/keycode_hub_pkg.sv
// keycode_hub_pkg
// Shared definitions for the keycode hub: Avalon register map, scan FSM
// state encoding and the layout of the 9-bit key event word.
package keycode_hub_pkg;

    // Avalon-MM register addresses
    localparam logic [1:0] ADDR_SLOT_WR = 2'd0;
    localparam logic [1:0] ADDR_COMMIT  = 2'd1;
    localparam logic [1:0] ADDR_EVENT   = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // Width of the slot index field that sits just above the keycode in SLOT_WR
    localparam int SLOT_IDX_W = 4;

    // Scan FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN_NEW = 2'd1,
        ST_SCAN_OLD = 2'd2,
        ST_COPY     = 2'd3
    } state_t;

    // Event word: {press, code}
    localparam int EVT_W         = 9;
    localparam int EVT_PRESS_BIT = 8;
    localparam int EVT_CODE_W    = 8;

    // Read-data bit positions
    localparam int RD_VALID_BIT  = 31;
    localparam int STAT_BUSY_BIT = 31;
    localparam int STAT_OVF_BIT  = 30;
    localparam int STAT_DROP_BIT = 29;

    function automatic logic [EVT_W-1:0] make_event(input logic press,
                                                    input logic [EVT_CODE_W-1:0] code);
        logic [EVT_W-1:0] ev;
        ev = '0;
        ev[EVT_PRESS_BIT] = press;
        ev[EVT_CODE_W-1:0] = code;
        return ev;
    endfunction

endpackage

// File: rtl/keycode_event_fifo.sv
// keycode_event_fifo
// Synchronous FIFO holding key events until software reads them.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset (pointers only)
//   push, push_data     enqueue request and event word
//   pop                 dequeue request (ignored when empty)
//   head                word at the head of the queue (valid when !empty)
//   count, full, empty  occupancy
module keycode_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/keycode_hub.sv
// keycode_hub
// Turns successive HID keycode reports into press/release events. Software
// fills a shadow report slot by slot, then COMMITs it; the hub diffs the new
// report against the previous one, one slot per cycle, queuing events in a
// FIFO that software drains through the EVENT register.
// Optional build macro: KEYCODE_HUB_ROLLOVER_EN -- when defined, a report in
// which every slot holds ErrorRollOver (0x01) is discarded at COMMIT.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   avs_*                   Avalon-MM slave, read latency 1, no waitrequest
//   keycode_export          slot 0 of the last committed report
//   watch_pressed[k]        watched keycode k is held in the last report
//   irq                     event FIFO not empty
module keycode_hub
    import keycode_hub_pkg::*;
#(
    parameter int NUM_SLOTS  = 6,
    parameter int KEY_W      = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_WATCH  = 4,
    parameter logic [NUM_WATCH*KEY_W-1:0] WATCH_CODES = {8'h52, 8'h51, 8'h1A, 8'h16}
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           avs_address,
    input  logic                 avs_write,
    input  logic [31:0]          avs_writedata,
    input  logic                 avs_read,
    output logic [31:0]          avs_readdata,
    output logic [KEY_W-1:0]     keycode_export,
    output logic [NUM_WATCH-1:0] watch_pressed,
    output logic                 irq
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [KEY_W-1:0]  shadow  [NUM_SLOTS];
    logic [KEY_W-1:0]  new_set [NUM_SLOTS];
    logic [KEY_W-1:0]  old_set [NUM_SLOTS];
    logic              overflow;
    logic              commit_drop;
    logic              busy;
    logic              rollover;
    logic              start_scan;

    logic                  wr_slot, wr_commit, wr_status, rd_event;
    logic [SLOT_IDX_W-1:0] wr_idx;
    logic [KEY_W-1:0]      wr_code;

    logic [KEY_W-1:0]     scan_code;
    logic                 in_other, dup, push_req;
    logic [NUM_WATCH-1:0] watch_next;

    logic [EVT_W-1:0]  fifo_head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, pop;
    logic [7:0]        count8;
    logic              unused_wdata;

    assign wr_slot   = avs_write && (avs_address == ADDR_SLOT_WR);
    assign wr_commit = avs_write && (avs_address == ADDR_COMMIT);
    assign wr_status = avs_write && (avs_address == ADDR_STATUS);
    assign rd_event  = avs_read  && (avs_address == ADDR_EVENT);
    assign wr_idx    = avs_writedata[KEY_W +: SLOT_IDX_W];
    assign wr_code   = avs_writedata[KEY_W-1:0];
    assign unused_wdata = ^avs_writedata[31:KEY_W+SLOT_IDX_W];

    assign busy       = (state != ST_IDLE);
    assign start_scan = wr_commit && !busy && !rollover;
    assign pop        = rd_event && !fifo_empty;
    assign irq        = !fifo_empty;
    assign count8     = 8'(fifo_count);

`ifdef KEYCODE_HUB_ROLLOVER_EN
    // A report made entirely of ErrorRollOver codes carries no key state
    always_comb begin
        rollover = 1'b1;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (shadow[i] != KEY_W'(1)) rollover = 1'b0;
    end
`else
    assign rollover = 1'b0;
`endif

    // Slot under scan is emitted if non-empty, missing from the other set and
    // not already seen at a lower slot of its own set.
    always_comb begin
        scan_code = (state == ST_SCAN_OLD) ? old_set[idx] : new_set[idx];
        in_other  = 1'b0;
        dup       = 1'b0;
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (((state == ST_SCAN_OLD) ? new_set[j] : old_set[j]) == scan_code)
                in_other = 1'b1;
            if ((j < int'(idx)) &&
                (((state == ST_SCAN_OLD) ? old_set[j] : new_set[j]) == scan_code))
                dup = 1'b1;
        end
        push_req = ((state == ST_SCAN_NEW) || (state == ST_SCAN_OLD)) &&
                   (scan_code != '0) && !in_other && !dup;
    end

    always_comb begin
        watch_next = '0;
        for (int k = 0; k < NUM_WATCH; k++)
            for (int j = 0; j < NUM_SLOTS; j++)
                if ((new_set[j] != '0) &&
                    (new_set[j] == WATCH_CODES[(NUM_WATCH-1-k)*KEY_W +: KEY_W]))
                    watch_next[k] = 1'b1;
    end

    // Control: FSM, scan index, sticky status
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            overflow    <= 1'b0;
            commit_drop <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_scan) begin
                        state <= ST_SCAN_NEW;
                        idx   <= '0;
                    end
                end
                ST_SCAN_NEW: begin
                    if (idx == LAST_IDX) begin
                        state <= ST_SCAN_OLD;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_SCAN_OLD: begin
                    if (idx == LAST_IDX) begin
                        state <= ST_COPY;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (wr_status) begin
                overflow    <= 1'b0;
                commit_drop <= 1'b0;
            end
            if (wr_commit && busy)               commit_drop <= 1'b1;
            if (push_req && fifo_full && !pop)   overflow    <= 1'b1;
        end
    end

    // Report sets and committed outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow[i]  <= '0;
                new_set[i] <= '0;
                old_set[i] <= '0;
            end
            keycode_export <= '0;
            watch_pressed  <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (wr_slot && (wr_idx == SLOT_IDX_W'(i))) shadow[i] <= wr_code;
                if (start_scan)                           new_set[i] <= shadow[i];
                if (state == ST_COPY)                     old_set[i] <= new_set[i];
            end
            if (state == ST_COPY) begin
                keycode_export <= new_set[0];
                watch_pressed  <= watch_next;
            end
        end
    end

    // Registered read data (latency 1)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            case (avs_address)
                ADDR_EVENT:  avs_readdata <= fifo_empty ? 32'd0
                                             : {1'b1, 22'd0, fifo_head};
                ADDR_STATUS: avs_readdata <= {busy, overflow, commit_drop, 21'd0, count8};
                default:     avs_readdata <= 32'd0;
            endcase
        end
    end

    keycode_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_req),
        .push_data (make_event(state == ST_SCAN_NEW, EVT_CODE_W'(scan_code))),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_keycode_hub.sv
// tb_keycode_hub
// Directed bench for keycode_hub with default parameters. Each scenario task
// drives Avalon transactions and checks results inline.
module tb_keycode_hub;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic [7:0]  keycode_export;
    logic [3:0]  watch_pressed;
    logic        irq;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    keycode_hub dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .avs_address    (avs_address),
        .avs_write      (avs_write),
        .avs_writedata  (avs_writedata),
        .avs_read       (avs_read),
        .avs_readdata   (avs_readdata),
        .keycode_export (keycode_export),
        .watch_pressed  (watch_pressed),
        .irq            (irq)
    );

    // All tasks start and end on a falling edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        avs_address = addr; avs_writedata = data; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_writedata = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        avs_address = addr; avs_read = 1'b1;
        @(negedge clk);
        avs_read = 1'b0;
        data = avs_readdata;
    endtask

    task automatic set_slot(input int slot, input logic [7:0] code);
        bus_write(2'd0, (32'(slot) << 8) | 32'(code));
    endtask

    task automatic commit();
        bus_write(2'd1, 32'd0);
    endtask

    task automatic wait_scan();
        repeat (16) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++; if (keycode_export !== 8'h00) $display("FAIL reset_export: got %h want 00", keycode_export); else passed++;
        checks++; if (watch_pressed !== 4'b0000) $display("FAIL reset_watch: got %b want 0000", watch_pressed); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq); else passed++;
        checks++; if (avs_readdata !== 32'h0) $display("FAIL reset_readdata: got %h want 0", avs_readdata); else passed++;
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) $display("FAIL reset_status: got %h want 00000000", d); else passed++;
    endtask

    task automatic test_single_press();
        logic [31:0] d;
        set_slot(0, 8'h52);
        commit();
        bus_read(2'd3, d);
        checks++; if (d[31] !== 1'b1) $display("FAIL busy_after_commit: got %b want 1", d[31]); else passed++;
        wait_scan();
        checks++; if (irq !== 1'b1) $display("FAIL press_irq: got %b want 1", irq); else passed++;
        checks++; if (watch_pressed !== 4'b0001) $display("FAIL press_watch: got %b want 0001", watch_pressed); else passed++;
        checks++; if (keycode_export !== 8'h52) $display("FAIL press_export: got %h want 52", keycode_export); else passed++;
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0000_0001) $display("FAIL press_status: got %h want 00000001", d); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0152) $display("FAIL press_event: got %h want 80000152", d); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL press_irq_after_pop: got %b want 0", irq); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) $display("FAIL empty_event_read: got %h want 00000000", d); else passed++;
    endtask

    task automatic test_press_release();
        logic [31:0] d;
        set_slot(0, 8'h51);
        set_slot(1, 8'h52);
        commit();
        wait_scan();
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0000_0001) $display("FAIL swap_status: got %h want 00000001", d); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0151) $display("FAIL swap_press51: got %h want 80000151", d); else passed++;
        set_slot(1, 8'h00);
        commit();
        wait_scan();
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0052) $display("FAIL swap_release52: got %h want 80000052", d); else passed++;
        checks++; if (watch_pressed !== 4'b0010) $display("FAIL swap_watch: got %b want 0010", watch_pressed); else passed++;
        checks++; if (keycode_export !== 8'h51) $display("FAIL swap_export: got %h want 51", keycode_export); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL swap_irq: got %b want 0", irq); else passed++;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  exp_codes [8];
        int          n;
        exp_codes = '{8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
        // Empty the report first so only presses follow
        set_slot(0, 8'h00);
        commit();
        wait_scan();
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0051) $display("FAIL ovf_clear_release: got %h want 80000051", d); else passed++;
        for (int i = 0; i < 6; i++) set_slot(i, 8'h04 + 8'(i));
        commit();
        wait_scan();
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0000_0006) $display("FAIL ovf_six_status: got %h want 00000006", d); else passed++;
        set_slot(3, 8'h0A);
        set_slot(4, 8'h0B);
        set_slot(5, 8'h0C);
        commit();
        wait_scan();
        bus_read(2'd3, d);
        checks++; if (d !== 32'h4000_0008) $display("FAIL ovf_status: got %h want 40000008", d); else passed++;
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd2, d);
            checks++;
            if (d !== (32'h8000_0100 | 32'(exp_codes[i])))
                $display("FAIL ovf_event%0d: got %h want %h", i, d, 32'h8000_0100 | 32'(exp_codes[i]));
            else passed++;
        end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) $display("FAIL ovf_ninth_lost: got %h want 00000000", d); else passed++;
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) $display("FAIL ovf_sticky_clear: got %h want 00000000", d); else passed++;
        for (int i = 0; i < 6; i++) set_slot(i, 8'h00);
        commit();
        wait_scan();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd2, d);
            if (d[31] === 1'b1) n++;
        end
        checks++; if (n != 6) $display("FAIL ovf_release_count: got %0d want 6", n); else passed++;
    endtask

    task automatic test_commit_drop();
        logic [31:0] d;
        set_slot(0, 8'h16);
        commit();
        set_slot(0, 8'h1A);
        @(negedge clk);
        commit();
        wait_scan();
        bus_read(2'd3, d);
        checks++; if (d !== 32'h2000_0001) $display("FAIL drop_status: got %h want 20000001", d); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0116) $display("FAIL drop_event: got %h want 80000116", d); else passed++;
        checks++; if (watch_pressed !== 4'b1000) $display("FAIL drop_watch: got %b want 1000", watch_pressed); else passed++;
        bus_write(2'd3, 32'd0);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) $display("FAIL drop_clear: got %h want 00000000", d); else passed++;
    endtask

    task automatic test_dup_and_reset();
        logic [31:0] d;
        // Shadow slot 0 already holds 0x1A from the dropped commit
        set_slot(1, 8'h1A);
        commit();
        wait_scan();
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0000_0002) $display("FAIL dup_status: got %h want 00000002", d); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_011A) $display("FAIL dup_press1a: got %h want 8000011a", d); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0016) $display("FAIL dup_release16: got %h want 80000016", d); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) $display("FAIL dup_no_third: got %h want 00000000", d); else passed++;
        checks++; if (watch_pressed !== 4'b0100) $display("FAIL dup_watch: got %b want 0100", watch_pressed); else passed++;
        set_slot(0, 8'h04);
        set_slot(1, 8'h05);
        set_slot(2, 8'h06);
        commit();
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++; if (keycode_export !== 8'h00) $display("FAIL midreset_export: got %h want 00", keycode_export); else passed++;
        checks++; if (watch_pressed !== 4'b0000) $display("FAIL midreset_watch: got %b want 0000", watch_pressed); else passed++;
        checks++; if (irq !== 1'b0) $display("FAIL midreset_irq: got %b want 0", irq); else passed++;
        reset_n = 1'b1;
        @(negedge clk);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h0) $display("FAIL midreset_status: got %h want 00000000", d); else passed++;
    endtask

    task automatic test_rollover();
        logic [31:0] d;
        set_slot(0, 8'h52);
        commit();
        wait_scan();
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0152) $display("FAIL ro_setup_event: got %h want 80000152", d); else passed++;
        for (int i = 0; i < 6; i++) set_slot(i, 8'h01);
        commit();
        wait_scan();
        bus_read(2'd3, d);
`ifdef KEYCODE_HUB_ROLLOVER_EN
        checks++; if (d !== 32'h0) $display("FAIL ro_status: got %h want 00000000", d); else passed++;
        checks++; if (keycode_export !== 8'h52) $display("FAIL ro_export: got %h want 52", keycode_export); else passed++;
        checks++; if (watch_pressed !== 4'b0001) $display("FAIL ro_watch: got %b want 0001", watch_pressed); else passed++;
`else
        checks++; if (d !== 32'h0000_0002) $display("FAIL ro_status: got %h want 00000002", d); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0101) $display("FAIL ro_press01: got %h want 80000101", d); else passed++;
        bus_read(2'd2, d);
        checks++; if (d !== 32'h8000_0052) $display("FAIL ro_release52: got %h want 80000052", d); else passed++;
        checks++; if (keycode_export !== 8'h01) $display("FAIL ro_export: got %h want 01", keycode_export); else passed++;
        checks++; if (watch_pressed !== 4'b0000) $display("FAIL ro_watch: got %b want 0000", watch_pressed); else passed++;
`endif
    endtask

    initial begin
        reset_n       = 1'b0;
        avs_address   = 2'd0;
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
        avs_read      = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        test_reset();
        test_single_press();
        test_press_release();
        test_overflow();
        test_commit_drop();
        test_dup_and_reset();
        test_rollover();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/keycode_hub.md
KEYCODE_HUB -- requirements
Module: keycode_hub

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 6, number of HID keycode slots per report.
REQ-002 SHALL have parameter KEY_W, default 8, keycode width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, event FIFO entries, power of two.
REQ-004 SHALL have parameter NUM_WATCH, default 4, number of watched keycodes.
REQ-005 SHALL have parameter WATCH_CODES, default {8'h52,8'h51,8'h1A,8'h16}, packed NUM_WATCH*KEY_W watch list.
REQ-006 SHALL have ports: clk  in  1  system clock; reset_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: avs_address  in  2; avs_write  in  1; avs_writedata  in  32; avs_read  in  1; avs_readdata  out  32 (Avalon-MM slave, read latency 1, no waitrequest).
REQ-008 SHALL have ports: keycode_export  out  KEY_W  committed slot 0; watch_pressed  out  NUM_WATCH  watched-key held flags; irq  out  1  event FIFO non-empty.

Function
REQ-009 SHALL decode addr 0 SLOT_WR: write stores writedata[KEY_W-1:0] into shadow slot writedata[KEY_W+3:KEY_W]; slot index >= NUM_SLOTS ignored.
REQ-010 SHALL decode addr 1 COMMIT: write when idle snapshots shadow into "new" set and starts scan; write while busy is dropped and sets sticky commit_drop.
REQ-011 SHALL decode addr 2 EVENT: read returns {valid[31], 22'b0, press[8], code[7:0]} of FIFO head and pops it; empty read returns 0, no pop.
REQ-012 SHALL decode addr 3 STATUS: read returns {busy[31], overflow[30], commit_drop[29], count[7:0]}; any write clears both sticky bits.
REQ-013 SHALL run FSM IDLE -> SCAN_NEW -> SCAN_OLD -> COPY -> IDLE, one slot per cycle in each scan state.
REQ-014 SHALL in SCAN_NEW slot i push press event when new[i]!=0, new[i] absent from "old" set, and new[i] not equal to any new[j], j<i.
REQ-015 SHALL in SCAN_OLD slot i push release event under the same rule with roles of old and new swapped.
REQ-016 SHALL in COPY load old <= new; busy deasserts after 2*NUM_SLOTS+1 cycles from the COMMIT write.
REQ-017 SHALL treat keycode 0 as empty slot; never produces events.
REQ-018 SHALL drop a push when FIFO full and set sticky overflow; push and pop in same cycle on full both succeed.
REQ-019 SHALL drive keycode_export = old[0] and watch_pressed[k] = (WATCH_CODES[k] present in old), registered, updated in COPY.
REQ-020 SHALL accept SLOT_WR writes while busy (shadow only; running scan unaffected).

Reset
REQ-021 SHALL on reset_n low clear shadow, new, old, FIFO pointers, sticky bits, FSM to IDLE; keycode_export=0, watch_pressed=0, irq=0, avs_readdata=0.
REQ-022 SHALL abort a scan in progress on reset with no partial event retained.

Configuration
REQ-023 SHALL when KEYCODE_HUB_ROLLOVER_EN is defined treat a committed set whose every slot equals 8'h01 (HID ErrorRollOver) as invalid: FSM stays IDLE, no events, old unchanged.
REQ-024 SHALL when KEYCODE_HUB_ROLLOVER_EN is undefined process 8'h01 as an ordinary keycode.

Structure
REQ-025 SHALL place register address constants, FSM state enum, and event field positions in shared package keycode_hub_pkg.
REQ-026 SHALL implement the event queue as sub-module keycode_event_fifo (parameterised depth, width 9, count output).

Verification
REQ-027 SHALL test: slots {0x52,0,0,0,0,0}, COMMIT -> one event {press=1,0x52}, irq=1, watch_pressed=4'b0001, keycode_export=0x52.
REQ-028 SHALL test: from above, commit {0x51,0x52,...0} then {0x51,0,...} -> events press 0x51, then release 0x52; watch_pressed=4'b0010.
REQ-029 SHALL test: 9 distinct presses with FIFO_DEPTH=8, no reads -> count=8, overflow=1, ninth event lost.
REQ-030 SHALL test: COMMIT issued 3 cycles after prior COMMIT -> commit_drop=1, only first set's events present.
REQ-031 SHALL test: duplicate slots {0x1A,0x1A,0,...} -> exactly one press 0x1A; reset asserted mid-SCAN_NEW -> all outputs 0, count=0.
REQ-032 SHALL test with KEYCODE_HUB_ROLLOVER_EN: all-0x01 commit -> no events, old set unchanged.
